// File: rtl/udp_rx_pkg.sv
// Shared constants for the UDP receive-buffer-to-FIFO drain stage.
package udp_rx_pkg;

    // FSM state encoding
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_LOAD = 4'd1;
    localparam logic [3:0] ST_HDR  = 4'd2;
    localparam logic [3:0] ST_READ = 4'd3;
    localparam logic [3:0] ST_DONE = 4'd4;

    // Largest payload accepted before truncation
    localparam int unsigned MAX_LEN_DEF = 2048;

    // Bytes in the optional length header
    localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/rd_skid.sv
// One-entry skid register behind the 1-cycle receive-buffer read latency.
// A byte arriving while the sink is stalled is parked here and offered
// first on the next ready cycle.
module rd_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready_c,
    output logic       m_valid_c,
    output logic [7:0] m_data_c,
    input  logic       m_ready
);

    logic       skid_v_q;
    logic       skid_v_d;
    logic [7:0] skid_data_q;
    logic [7:0] skid_data_d;

    // Skid storage registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_v_q    <= 1'b0;
            skid_data_q <= 8'h00;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Park an unaccepted byte, release it once the sink is ready
    always_comb begin
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (skid_v_q) begin
            if (m_ready) begin
                skid_v_d = 1'b0;
            end
        end else if (s_valid && !m_ready) begin
            skid_v_d    = 1'b1;
            skid_data_d = s_data;
        end
    end

    assign s_ready_c = !skid_v_q;
    assign m_valid_c = skid_v_q || s_valid;
    assign m_data_c  = skid_v_q ? skid_data_q : s_data;

endmodule

// File: rtl/udp_rx2fifo.sv
// Drains a received UDP payload from the MAC receive buffer into the
// receive-side FIFO, then acknowledges with fd until the MAC drops fs.
// Optional macro UDP_RX2FIFO_LEN_HDR_EN prepends a 2-byte length header.
// fifo_full is evaluated in the cycle that decides a write; the registered
// fifo_txen/fifo_txd for that write follow on the next cycle.
module udp_rx2fifo
    import udp_rx_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fs,
    output logic              fd,
    input  logic [LEN_W-1:0]  udp_rx_len,
    output logic [ADDR_W-1:0] udp_rx_addr,
    input  logic [7:0]        udp_rxd,
    input  logic              fifo_full,
    output logic              fifo_txen,
    output logic [7:0]        fifo_txd,
    output logic              busy,
    output logic              err,
    output logic [15:0]       pkt_cnt
);

    logic [3:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              pipe_v_q, pipe_v_d;
    logic              fd_q, fd_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              txen_q, txen_d;
    logic [7:0]        txd_q, txd_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              rx_len_over_c;
    logic [LEN_W-1:0]  rx_len_clamped_c;
    logic [LEN_W-1:0]  wr_target_c;
    logic [LEN_W-1:0]  wr_next_c;
    logic              issue_c;
    logic              wr_fire_c;
    logic [7:0]        wr_byte_c;
    logic              sk_s_ready_c;
    logic              sk_m_valid_c;
    logic [7:0]        sk_m_data_c;

    assign rx_len_over_c    = (udp_rx_len > LEN_W'(MAX_LEN));
    assign rx_len_clamped_c = rx_len_over_c ? LEN_W'(MAX_LEN) : udp_rx_len;

`ifdef UDP_RX2FIFO_LEN_HDR_EN
    logic [15:0] hdr_len_c;
    assign hdr_len_c   = 16'(len_q);
    assign wr_target_c = len_q + LEN_W'(HDR_BYTES);
`else
    assign wr_target_c = len_q;
`endif

    // Read-data skid: absorbs a byte already in flight when the FIFO fills
    rd_skid u_rd_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (pipe_v_q),
        .s_data    (udp_rxd),
        .s_ready_c (sk_s_ready_c),
        .m_valid_c (sk_m_valid_c),
        .m_data_c  (sk_m_data_c),
        .m_ready   (!fifo_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read issue and FIFO write decision for the current cycle.
    // Issue is also withheld while full: a byte issued then could arrive
    // while the single skid entry is already occupied.
    always_comb begin
        issue_c   = 1'b0;
        wr_fire_c = 1'b0;
        wr_byte_c = 8'h00;
        case (state_q)
`ifdef UDP_RX2FIFO_LEN_HDR_EN
            ST_HDR: begin
                if (!fifo_full) begin
                    wr_fire_c = 1'b1;
                    wr_byte_c = (wr_cnt_q == '0) ? hdr_len_c[15:8] : hdr_len_c[7:0];
                end
            end
`endif
            ST_READ: begin
                issue_c = (rd_cnt_q < len_q) && sk_s_ready_c && !fifo_full;
                if (sk_m_valid_c && !fifo_full) begin
                    wr_fire_c = 1'b1;
                    wr_byte_c = sk_m_data_c;
                end
            end
            default: ;
        endcase
        wr_next_c = wr_cnt_q + LEN_W'(wr_fire_c);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fs) begin
`ifdef UDP_RX2FIFO_LEN_HDR_EN
                    state_d = ST_LOAD;
`else
                    state_d = (rx_len_clamped_c == '0) ? ST_DONE : ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
`ifdef UDP_RX2FIFO_LEN_HDR_EN
                state_d = ST_HDR;
`else
                state_d = ST_READ;
`endif
            end
`ifdef UDP_RX2FIFO_LEN_HDR_EN
            ST_HDR: begin
                if (wr_next_c == wr_target_c) begin
                    state_d = ST_DONE;
                end else if (wr_next_c == LEN_W'(HDR_BYTES)) begin
                    state_d = ST_READ;
                end
            end
`endif
            ST_READ: begin
                if (wr_next_c == wr_target_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!fs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_next_c;
        pipe_v_d  = issue_c;
        err_d     = 1'b0;
        txen_d    = wr_fire_c;
        txd_d     = wr_fire_c ? wr_byte_c : txd_q;
        fd_d      = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
        pkt_cnt_d = pkt_cnt_q;

        if (state_q == ST_IDLE && fs) begin
            len_d = rx_len_clamped_c;
            err_d = rx_len_over_c;
        end
        if (state_q == ST_LOAD) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
        if (issue_c) begin
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
        end
        if (state_q == ST_DONE && !fs) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        addr_d = rd_cnt_d[ADDR_W-1:0];
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            pipe_v_q  <= 1'b0;
            fd_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            txen_q    <= 1'b0;
            txd_q     <= 8'h00;
            pkt_cnt_q <= 16'h0000;
            addr_q    <= '0;
        end else begin
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            pipe_v_q  <= pipe_v_d;
            fd_q      <= fd_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            txen_q    <= txen_d;
            txd_q     <= txd_d;
            pkt_cnt_q <= pkt_cnt_d;
            addr_q    <= addr_d;
        end
    end

    assign fd          = fd_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign fifo_txen   = txen_q;
    assign fifo_txd    = txd_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign udp_rx_addr = addr_q;

endmodule

// File: tb/tb_udp_rx2fifo.sv
// Directed-plus-random bench for udp_rx2fifo. Expected FIFO streams are
// built from the buffer contents and the clamped length; a sink process
// records every write and drives fifo_full.
module tb_udp_rx2fifo;

    localparam int unsigned MAXL = 2048;
`ifdef UDP_RX2FIFO_LEN_HDR_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs = 1'b0;
    logic [15:0] udp_rx_len = 16'h0;
    logic [7:0]  udp_rxd = 8'h00;
    logic        fifo_full = 1'b0;
    logic        fd, fifo_txen, busy, err;
    logic [10:0] udp_rx_addr;
    logic [7:0]  fifo_txd;
    logic [15:0] pkt_cnt;

    logic [7:0]  mem [0:2047];
    logic [7:0]  got [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          first_wr = -1;
    int          err_seen = 0;
    int          full_viol = 0;
    int          full_mode = 0;
    int          win_left = 0;
    bit          win_used = 1'b0;
    bit          full_prev = 1'b0;
    int          ref_pkts = 0;

    udp_rx2fifo #(.ADDR_W(11), .LEN_W(16), .MAX_LEN(2048)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fs          (fs),
        .fd          (fd),
        .udp_rx_len  (udp_rx_len),
        .udp_rx_addr (udp_rx_addr),
        .udp_rxd     (udp_rxd),
        .fifo_full   (fifo_full),
        .fifo_txen   (fifo_txen),
        .fifo_txd    (fifo_txd),
        .busy        (busy),
        .err         (err),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 clk = ~clk;

    // MAC receive buffer: one-cycle read latency
    always @(posedge clk) begin
        udp_rxd <= mem[udp_rx_addr];
        cyc <= cyc + 1;
    end

    // FIFO sink: records writes, checks each write was decided while not
    // full, and drives the fifo_full pattern selected by full_mode
    always @(negedge clk) begin
        if (fifo_txen === 1'b1) begin
            got.push_back(fifo_txd);
            if (full_prev) full_viol++;
            if (first_wr < 0) first_wr = cyc;
        end
        if (err === 1'b1) err_seen++;
        case (full_mode)
            1: fifo_full = ($urandom_range(0, 99) < 30);
            2: begin
                if (!win_used && got.size() == 4) begin
                    win_left = 5;
                    win_used = 1'b1;
                end
                fifo_full = (win_left > 0);
                if (win_left > 0) win_left--;
            end
            default: fifo_full = 1'b0;
        endcase
        full_prev = fifo_full;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One packet: offer it, wait for fd, release fs, compare the stream
    task automatic run_pkt(input string tag, input int unsigned len, input int mode, input bit early);
        logic [7:0]  exp_q [$];
        int unsigned lc;
        int          k;
        int          nmis;
        int          fs_cyc;
        lc = (len > MAXL) ? MAXL : len;
`ifdef UDP_RX2FIFO_LEN_HDR_EN
        exp_q.push_back(8'(lc >> 8));
        exp_q.push_back(8'(lc));
`endif
        for (int i = 0; i < int'(lc); i++) exp_q.push_back(mem[i]);

        got.delete();
        first_wr = -1;
        err_seen = 0;
        full_viol = 0;
        win_used = 1'b0;
        win_left = 0;
        full_mode = mode;
        fs = 1'b1;
        udp_rx_len = 16'(len);
        fs_cyc = cyc;
        k = 0;
        while (fd !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
            if (early && k == 2) fs = 1'b0;
        end
        chk($sformatf("%s.fd", tag), 32'(fd), 1);
`ifndef UDP_RX2FIFO_LEN_HDR_EN
        if (lc == 0) chk($sformatf("%s.fd_within2", tag), 32'(k <= 2), 1);
`endif
        chk($sformatf("%s.busy_done", tag), 32'(busy), 1);
        @(negedge clk);
        fs = 1'b0;
        udp_rx_len = 16'h0;
        full_mode = 0;
        k = 0;
        while (busy !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s.idle", tag), 32'({busy, fd}), 0);

        chk($sformatf("%s.count", tag), 32'(got.size()), 32'(exp_q.size()));
        nmis = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) nmis++;
        chk($sformatf("%s.data", tag), 32'(nmis), 0);
        chk($sformatf("%s.full_viol", tag), 32'(full_viol), 0);
        chk($sformatf("%s.err", tag), 32'(err_seen), (len > MAXL) ? 1 : 0);
        if (mode == 0 && exp_q.size() > 0)
            chk($sformatf("%s.latency", tag), 32'(first_wr - (fs_cyc + 1)), 32'(LAT));
        ref_pkts = (ref_pkts + 1) % 65536;
        chk($sformatf("%s.pkt_cnt", tag), 32'(pkt_cnt), 32'(ref_pkts));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.ctl", 32'({fd, busy, err, fifo_txen}), 0);
        chk("reset.txd", 32'(fifo_txd), 0);
        chk("reset.addr", 32'(udp_rx_addr), 0);
        chk("reset.pkt_cnt", 32'(pkt_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 12-byte packet, then same packet with a 5-cycle full burst
        run_pkt("basic12", 12, 0, 1'b0);
        run_pkt("full5", 12, 2, 1'b0);

        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

        // Truncation, zero length, header-sized length, early fs drop
        run_pkt("trunc3000", 3000, 1, 1'b0);
        run_pkt("zero", 0, 0, 1'b0);
        run_pkt("len258", 258, 0, 1'b0);
        run_pkt("early_fs", 40, 0, 1'b1);
        for (int n = 0; n < 4; n++)
            run_pkt($sformatf("rand%0d", n), $urandom_range(1, 300), 1, 1'b0);
        run_pkt("max2048", 2048, 0, 1'b0);

        // Reset in the middle of a 12-byte packet
        for (int i = 0; i < 12; i++) mem[i] = 8'(i);
        got.delete();
        full_mode = 0;
        fs = 1'b1;
        udp_rx_len = 16'd12;
        k = 0;
        while (got.size() < 6 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("midrst.reach", 32'(got.size() >= 6), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fs = 1'b0;
        udp_rx_len = 16'h0;
        chk("midrst.ctl", 32'({fd, busy, err, fifo_txen}), 0);
        chk("midrst.txd", 32'(fifo_txd), 0);
        chk("midrst.addr", 32'(udp_rx_addr), 0);
        chk("midrst.pkt_cnt", 32'(pkt_cnt), 0);
        ref_pkts = 0;
        @(negedge clk);
        run_pkt("after_rst", 12, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
